// File: rtl/wb_pkg.sv
// Shared definitions for the write-back sequencer: mux source codes, FSM states
// and the source-class decode used to pick which ready input a request waits on.
package wb_pkg;

   localparam logic [3:0] WD_MDR7     = 4'd0;
   localparam logic [3:0] WD_MDR15    = 4'd1;
   localparam logic [3:0] WD_ALUOUT   = 4'd2;
   localparam logic [3:0] WD_MDR      = 4'd3;
   localparam logic [3:0] WD_HI       = 4'd4;
   localparam logic [3:0] WD_ALU      = 4'd5;
   localparam logic [3:0] WD_LO       = 4'd6;
   localparam logic [3:0] WD_REGDESL  = 4'd7;
   localparam logic [3:0] WD_SHIFTL16 = 4'd8;
   localparam logic [3:0] WD_LT       = 4'd9;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_SRC,
      WRITE,
      ERR
   } wb_state_t;

   typedef enum logic [2:0] {
      CLS_MEM,
      CLS_MULDIV,
      CLS_SHIFT,
      CLS_IMM,
      CLS_ILLEGAL
   } src_class_t;

   function automatic src_class_t src_class(input logic [3:0] src);
      case (src)
         WD_MDR7, WD_MDR15, WD_MDR:              return CLS_MEM;
         WD_HI, WD_LO:                           return CLS_MULDIV;
         WD_REGDESL:                             return CLS_SHIFT;
         WD_ALUOUT, WD_ALU, WD_SHIFTL16, WD_LT:  return CLS_IMM;
         default:                                return CLS_ILLEGAL;
      endcase
   endfunction

endpackage

// File: rtl/wb_sequencer.sv
// Write-back sequencer: owns every register-file write and the write-data mux select.
// Latency: IMM source 1 cycle; waited source 1 cycle after its ready is seen; timeout TIMEOUT+1.
// Backpressure: one request at a time; wb_req is held by the requester until wb_ack.
module wb_sequencer
   import wb_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       wb_req,
   input  logic [3:0] wb_src,
   input  logic [4:0] wb_dst,
   input  logic       mdr_ready,
   input  logic       muldiv_done,
   input  logic       shift_done,
   input  logic       flush,
   output logic [3:0] WriteDataCtrl,
   output logic       RegWrite,
   output logic [4:0] WriteReg,
   output logic       wb_ack,
   output logic       wb_err,
   output logic       busy
);

   localparam int CW = $clog2(TIMEOUT + 1);

   wb_state_t        state;
   logic [3:0]       src_q;
   logic [4:0]       dst_q;
   logic [CW-1:0]    cnt;
   logic             sticky;
   src_class_t       req_cls;
   logic             req_rdy;
   logic             wait_rdy;

   function automatic logic class_rdy(input src_class_t c, input logic mdr,
                                      input logic md, input logic sh);
      case (c)
         CLS_MEM:    return mdr;
         CLS_MULDIV: return md;
         CLS_SHIFT:  return sh;
         default:    return 1'b0;
      endcase
   endfunction

   // req_rdy lets a ready pulse in the acceptance cycle land in the sticky bit
   always_comb begin
      req_cls  = src_class(wb_src);
      req_rdy  = class_rdy(req_cls, mdr_ready, muldiv_done, shift_done);
      wait_rdy = class_rdy(src_class(src_q), mdr_ready, muldiv_done, shift_done);
   end

   // Outputs are loaded on the edge that enters each state, so they are pure register decodes
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= IDLE;
         src_q         <= '0;
         dst_q         <= '0;
         cnt           <= '0;
         sticky        <= 1'b0;
         WriteDataCtrl <= '0;
         RegWrite      <= 1'b0;
         WriteReg      <= '0;
         wb_ack        <= 1'b0;
         wb_err        <= 1'b0;
         busy          <= 1'b0;
      end else begin
         WriteDataCtrl <= '0;
         RegWrite      <= 1'b0;
         WriteReg      <= '0;
         wb_ack        <= 1'b0;
         wb_err        <= 1'b0;
         busy          <= 1'b0;
         case (state)
            IDLE: begin
               if (wb_req) begin
                  src_q  <= wb_src;
                  dst_q  <= wb_dst;
                  cnt    <= '0;
                  sticky <= req_rdy;
                  busy   <= 1'b1;
                  case (req_cls)
                     CLS_ILLEGAL: begin
                        state  <= ERR;
                        wb_ack <= 1'b1;
                        wb_err <= 1'b1;
                     end
                     CLS_IMM: begin
                        state         <= WRITE;
                        WriteDataCtrl <= wb_src;
                        RegWrite      <= (wb_dst != 5'd0);
                        WriteReg      <= wb_dst;
                        wb_ack        <= 1'b1;
                     end
                     default: begin
                        state         <= WAIT_SRC;
                        WriteDataCtrl <= wb_src;
                     end
                  endcase
               end
            end
            WAIT_SRC: begin
               sticky <= sticky | wait_rdy;
               if (flush) begin
                  state <= IDLE;
               end else if (sticky || wait_rdy) begin
                  state         <= WRITE;
                  WriteDataCtrl <= src_q;
                  RegWrite      <= (dst_q != 5'd0);
                  WriteReg      <= dst_q;
                  wb_ack        <= 1'b1;
                  busy          <= 1'b1;
               end else if (cnt == CW'(TIMEOUT)) begin
                  state  <= ERR;
                  wb_ack <= 1'b1;
                  wb_err <= 1'b1;
                  busy   <= 1'b1;
               end else begin
                  cnt           <= cnt + CW'(1);
                  WriteDataCtrl <= src_q;
                  busy          <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/wb_sequencer.md
# wb_sequencer

Write-back sequencer for the multicycle datapath. It accepts one register-file write-back request at a time and drives the 4-bit write-data mux select `WriteDataCtrl`. It waits until the selected source is valid (memory data register, mult/div unit or shifter), then issues a single-cycle `RegWrite` with the destination index. It sits between the main control unit and the register file / write-data mux, and owns every register-file write.

## Interface
Parameters:
- `TIMEOUT`, 255, max cycles spent in WAIT_SRC before aborting with error (1..1023)

Ports:
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `wb_req`  in  1  write-back request; held by requester until `wb_ack`
- `wb_src`  in  4  mux source code: 0 MDR7, 1 MDR15, 2 AluOut, 3 MDR, 4 HI, 5 ALU, 6 LO, 7 RegDesl, 8 ShiftL16, 9 LT
- `wb_dst`  in  5  destination register index
- `mdr_ready`  in  1  MDR holds valid data (pulse or level)
- `muldiv_done`  in  1  HI/LO valid (pulse or level)
- `shift_done`  in  1  shifter output valid (pulse or level)
- `flush`  in  1  abort a pending request (exception/branch squash)
- `WriteDataCtrl`  out  4  mux select
- `RegWrite`  out  1  register-file write enable
- `WriteReg`  out  5  register-file write index
- `wb_ack`  out  1  one-cycle completion pulse
- `wb_err`  out  1  one-cycle error pulse, coincident with `wb_ack`
- `busy`  out  1  high in any state other than IDLE

## Operation
- Source classes:
  - MEM = {0,1,3}, waits `mdr_ready`
  - MULDIV = {4,6}, waits `muldiv_done`
  - SHIFT = {7}, waits `shift_done`
  - IMM = {2,5,8,9}, always ready
  - ILLEGAL = {10..15}
- States:
  - IDLE:
    - `wb_req`=1 latches `wb_src`/`wb_dst` and clears the wait counter and sticky ready bit.
    - ILLEGAL goes to ERR. IMM goes to WRITE. Otherwise goes to WAIT_SRC.
  - WAIT_SRC:
    - Counter increments each cycle.
    - Sticky ready (set by the class's ready input) goes to WRITE.
    - Counter == TIMEOUT with no ready goes to ERR.
    - `flush` goes to IDLE with no ack.
  - WRITE:
    - `RegWrite`=1 (0 if latched dst == 0), `wb_ack`=1.
    - Next state is IDLE.
  - ERR:
    - `wb_ack`=1, `wb_err`=1, `RegWrite`=0.
    - Next state is IDLE.
- `WriteDataCtrl` = latched src in WAIT_SRC and WRITE; 0 in IDLE and ERR. `WriteReg` = latched dst in WRITE, else 0.
- The sticky ready bit captures a class-matching ready pulse in the acceptance cycle and any later cycle. Ready inputs of other classes are ignored.
- `wb_req` is not sampled outside IDLE. A request still asserted in the cycle after ack is a new request.
- Priority in WAIT_SRC: `flush` > ready > timeout.
- `flush` in IDLE, WRITE or ERR has no effect; an in-flight WRITE always completes.

## Timing
- Reset (async assert, sync release): state IDLE; all outputs 0; counter 0; sticky 0.
- IMM source: request sampled at edge N; WRITE cycle N+1 (`RegWrite`, `wb_ack`); IDLE at N+2. Minimum latency is 1 cycle, throughput 1 request per 2 cycles.
- Waited source with ready seen at edge M: WRITE cycle M+1.
- Timeout: ERR cycle occurs TIMEOUT+1 cycles after acceptance.
- `reset` asserted mid-operation: immediate return to IDLE. `RegWrite` drops asynchronously; no ack is issued.
- All outputs are registered state decodes; no combinational path from inputs to outputs.

## Structure
- Shared package `wb_pkg`:
  - source-code constants `WD_MDR7`..`WD_LT`
  - state enum {IDLE, WAIT_SRC, WRITE, ERR}
  - source-class enum, and pure function `src_class(src)`
- Wait counter width is `$clog2(TIMEOUT+1)`.
- Single module; no sub-module needed.

## Test plan
- IMM: req src=5, dst=8 → next cycle `WriteDataCtrl`=5, `RegWrite`=1, `WriteReg`=8, `wb_ack`=1; IDLE after.
- MEM: req src=3, dst=4, `mdr_ready` pulse 3 cycles later → WRITE exactly 1 cycle after the pulse. Repeat with the pulse in the acceptance cycle → WRITE on the next cycle (sticky).
- Timeout: TIMEOUT=4, src=4, no `muldiv_done` → ERR pulse (`wb_ack`=`wb_err`=1, `RegWrite`=0) 5 cycles after acceptance. A wrong-class `shift_done` during the wait is ignored.
- Illegal/dst0: src=12 → ERR next cycle. src=2, dst=0 → `wb_ack`=1, `RegWrite`=0.
- Flush/reset: `flush` while waiting → IDLE, no ack, next req accepted. `reset` low during WRITE → `RegWrite`=0 immediately and all outputs 0.
- Back-to-back: `wb_req` held high across 3 IMM requests → ack every 2nd cycle, `busy` toggling.
